// File: rtl/ndp_result_drain_if.sv
// Host-side result stream: one OUT_WIDTH word per accepted valid/ready beat.
interface ndp_result_drain_if #(
    parameter int OUT_WIDTH = 32
);
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ndp_result_drain.sv
// Snapshots the NDP core result bus on each calc_done_flag rise and streams it
// to the host word by word, lowest word first, then pulses drain_done.
//
// state  | meaning
// IDLE   | no snapshot held; waiting for a calc_done_flag rise
// STREAM | snapshot held; presenting words until the last one is accepted
module ndp_result_drain #(
    parameter int WIDTH      = 16,
    parameter int ARR_WIDTH  = 4,
    parameter int ARR_HEIGHT = 4,
    parameter int SYS_WIDTH  = 64,
    parameter int SYS_HEIGHT = 1,
    parameter int OUT_WIDTH  = 32,
    localparam int TOTAL_BITS = ARR_WIDTH * SYS_WIDTH * ARR_HEIGHT * SYS_HEIGHT * WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  calc_done_flag,
    input  logic [TOTAL_BITS-1:0] out_c,
    ndp_result_drain_if.master    host,
    output logic                  busy,
    output logic                  drain_done,
    output logic                  overrun_err
);
    localparam int NUM_WORDS = TOTAL_BITS / OUT_WIDTH;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    generate
        if (TOTAL_BITS % OUT_WIDTH != 0) begin : g_bad_width
            $error("ndp_result_drain: TOTAL_BITS must be a multiple of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state, state_n;
    logic [TOTAL_BITS-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  done_q;
    logic                  valid_q, valid_n;
    logic                  last_q, last_n;
    logic                  busy_n, drain_done_n, overrun_n;
    logic                  rise, beat;

    assign rise = calc_done_flag && !done_q;
    assign beat = valid_q && host.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            done_q      <= 1'b1;  // a level already high at reset release is stale
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy        <= 1'b0;
            drain_done  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            cnt         <= cnt_n;
            done_q      <= calc_done_flag;
            valid_q     <= valid_n;
            last_q      <= last_n;
            busy        <= busy_n;
            drain_done  <= drain_done_n;
            overrun_err <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        valid_n      = valid_q;
        last_n       = last_q;
        busy_n       = busy;
        drain_done_n = 1'b0;
        overrun_n    = overrun_err;

        case (state)
            IDLE: begin
                if (rise) begin
                    shreg_n = out_c;
                    cnt_n   = '0;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    last_n  = (NUM_WORDS == 1);
                    state_n = STREAM;
                end
            end
            STREAM: begin
                // A result arriving mid-drain is dropped, including on the final beat.
                if (rise) begin
                    overrun_n = 1'b1;
                end
                if (beat) begin
                    shreg_n = shreg >> OUT_WIDTH;
                    if (cnt == LAST_CNT) begin
                        valid_n      = 1'b0;
                        last_n       = 1'b0;
                        busy_n       = 1'b0;
                        drain_done_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        cnt_n  = cnt + CNT_W'(1);
                        last_n = ((cnt + CNT_W'(1)) == LAST_CNT);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign host.out_valid = valid_q;
    assign host.out_last  = last_q;
    assign host.out_data  = shreg[OUT_WIDTH-1:0];
endmodule
